// File: rtl/gate_stim_pkg.sv
// gate_stim_pkg: shared state encoding and counter width helper for gate_stim_seq
package gate_stim_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/gate_ref_check.sv
// gate_ref_check: compares sampled gate output with AND of the vector, saturating error count and first-error capture
module gate_ref_check #(
  parameter int N_IN = 2,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_samp,
  input  logic [N_IN-1:0] i_vec,
  input  logic            i_c,
  output logic [CW-1:0]   o_err_cnt,
  output logic [N_IN-1:0] o_err_idx
);
  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_idx;
  logic            r_seen;
  logic            w_miss;
  assign w_miss    = i_samp && (i_c != &i_vec);
  assign o_err_cnt = r_cnt;
  assign o_err_idx = r_idx;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_seen <= 1'b0;
    end else if (w_miss) begin
      r_cnt <= &r_cnt ? r_cnt : r_cnt + 1'b1;
      if (!r_seen) begin
        r_seen <= 1'b1;
        r_idx  <= i_vec;
      end
    end
  end
endmodule

// File: rtl/gate_stim_seq.sv
// gate_stim_seq: walks all gate input vectors, HOLD cycles each, LOOPS passes per start
// Defining GATE_STIM_CHECK_EN adds the gate_ref_check checker on c; otherwise err outputs stay 0.
module gate_stim_seq
  import gate_stim_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int HOLD  = 20,
  parameter int LOOPS = 1,
  parameter int CW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  input  logic            c,
  output logic [N_IN-1:0] vec,
  output logic            valid,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   err_cnt,
  output logic [N_IN-1:0] err_idx
);
  localparam int HW = cnt_w(HOLD);
  localparam int LW = cnt_w(LOOPS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);
  state_t          r_state;
  logic [HW-1:0]   r_hold;
  logic [LW-1:0]   r_loop;
  logic [N_IN-1:0] r_vec;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;
  logic            w_hold_end;
  assign w_hold_end = (r_hold == HOLD_LAST);
  assign vec   = r_vec;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign done  = r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_loop  <= '0;
      r_vec   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
          r_valid <= 1'b1;
          r_vec   <= '0;
          r_hold  <= '0;
          r_loop  <= '0;
        end
        RUN: if (!stall) begin
          r_hold <= w_hold_end ? '0 : r_hold + 1'b1;
          if (w_hold_end) begin
            r_vec <= r_vec + 1'b1;
            if (&r_vec) begin
              r_loop <= r_loop + 1'b1;
              if (r_loop == LOOP_LAST) begin
                r_state <= DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_valid <= 1'b0;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef GATE_STIM_CHECK_EN
  logic w_clr;
  logic w_samp;
  assign w_clr  = (r_state == IDLE) && start;
  assign w_samp = (r_state == RUN) && !stall && w_hold_end;
  gate_ref_check #(.N_IN(N_IN), .CW(CW)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_samp   (w_samp),
    .i_vec    (r_vec),
    .i_c      (c),
    .o_err_cnt(err_cnt),
    .o_err_idx(err_idx)
  );
`else
  logic w_unused;
  assign w_unused = c;
  assign err_cnt  = '0;
  assign err_idx  = '0;
`endif
endmodule

// File: tb/tb_gate_stim_seq.sv
// tb_gate_stim_seq: randomized run/stall/start stimulus checked every cycle against a progress-count model
module tb_gate_stim_seq;
  typedef struct {
    bit run;
    bit done;
    bit seen;
    int p;
    int err;
    int idx;
  } m_t;
  logic clk = 0, rst = 1;
  logic start0 = 0, stall0 = 0, or0 = 0, start1 = 0, stall1 = 0;
  logic c0, c1;
  logic [1:0] vec0, vec1, ei0, ei1;
  logic [7:0] ec0, ec1;
  logic valid0, busy0, done0, valid1, busy1, done1;
  int n_tests = 0, n_fail = 0;
  bit chk_on = 0;
  m_t m0, m1;
  assign c0 = or0 ? |vec0 : &vec0;
  assign c1 = &vec1;
  always #5 clk = ~clk;
  gate_stim_seq #(.N_IN(2), .HOLD(20), .LOOPS(1), .CW(8)) u0 (
    .clk(clk), .rst(rst), .start(start0), .stall(stall0), .c(c0),
    .vec(vec0), .valid(valid0), .busy(busy0), .done(done0), .err_cnt(ec0), .err_idx(ei0)
  );
  gate_stim_seq #(.N_IN(2), .HOLD(1), .LOOPS(2), .CW(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stall(stall1), .c(c1),
    .vec(vec1), .valid(valid1), .busy(busy1), .done(done1), .err_cnt(ec1), .err_idx(ei1)
  );
  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
    end
  endtask
  function automatic int exp_err(input int e);
`ifdef GATE_STIM_CHECK_EN
    return e;
`else
    return 0;
`endif
  endfunction
  // Model tracks only unstalled progress p since start; vector is p/HOLD mod 4.
  function automatic m_t step(input m_t m, input bit r, input bit s, input bit st, input bit orr,
                              input int hold, input int total);
    int v;
    bit g;
    if (r) begin
      m = '{default: 0};
      return m;
    end
    if (m.done) m.done = 0;
    else if (!m.run) begin
      if (s) begin
        m.run = 1; m.p = 0; m.err = 0; m.idx = 0; m.seen = 0;
      end
    end else if (!st) begin
      v = (m.p / hold) % 4;
      g = orr ? (v != 0) : (v == 3);
      if ((m.p % hold == hold - 1) && (g != (v == 3))) begin
        if (m.err < 255) m.err++;
        if (!m.seen) begin
          m.seen = 1;
          m.idx = v;
        end
      end
      m.p++;
      if (m.p == total) begin
        m.run = 0;
        m.done = 1;
      end
    end
    return m;
  endfunction
  always @(posedge clk) begin
    m0 = step(m0, rst, start0, stall0, or0, 20, 80);
    m1 = step(m1, rst, start1, stall1, 1'b0, 1, 8);
  end
  always @(negedge clk) if (chk_on) begin
    check("vec0", vec0, m0.run ? (m0.p / 20) % 4 : 0);
    check("valid0", valid0, m0.run);
    check("busy0", busy0, m0.run);
    check("done0", done0, m0.done);
    check("errcnt0", ec0, exp_err(m0.err));
    check("erridx0", ei0, exp_err(m0.idx));
    check("vec1", vec1, m1.run ? m1.p % 4 : 0);
    check("busy1", busy1, m1.run);
    check("done1", done1, m1.done);
    check("errcnt1", ec1, exp_err(m1.err));
  end
  task automatic run0(input int a, input int l, input bit rnd, output int n, output int ns);
    n = 0;
    ns = 0;
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    while (!done0 && n < 2000) begin
      stall0 = (n >= a && n < a + l) || (rnd && $urandom_range(0, 3) == 0);
      start0 = rnd && ($urandom_range(0, 7) == 0);
      ns += int'(stall0);
      @(negedge clk);
      n++;
    end
    stall0 = 0;
    start0 = 0;
    if (!done0) check("timeout0", 0, 1);
  endtask
  initial begin
    int n, ns;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_on = 1;
    check("rst_vec", vec0, 0);
    check("rst_busy", busy0, 0);
    check("rst_valid", valid0, 0);
    check("rst_done", done0, 0);
    check("rst_err", ec0, 0);
    check("rst_idx", ei0, 0);
    run0(1000, 0, 0, n, ns);
    check("lat_and", n, 80);
    check("err_and", ec0, 0);
    @(negedge clk);
    check("busy_after", busy0, 0);
    or0 = 1;
    run0(1000, 0, 0, n, ns);
    check("lat_or", n, 80);
    check("err_or", ec0, exp_err(2));
    check("idx_or", ei0, exp_err(1));
    or0 = 0;
    repeat (2) @(negedge clk);
    run0(45, 5, 0, n, ns);
    check("lat_stall", n, 85);
    check("err_stall", ec0, 0);
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    repeat (30) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mrst_busy", busy0, 0);
    check("mrst_vec", vec0, 0);
    check("mrst_done", done0, 0);
    repeat (3) @(negedge clk);
    run0(1000, 0, 0, n, ns);
    check("lat_restart", n, 80);
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    n = 0;
    repeat (2) begin
      @(negedge clk);
      n++;
    end
    start1 = 1;
    @(negedge clk);
    n++;
    start1 = 0;
    while (!done1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("lat_h1", n, 8);
    for (int i = 0; i < 12; i++) begin
      or0 = 1'($urandom);
      repeat ($urandom_range(1, 4)) begin
        stall0 = 1'($urandom);
        @(negedge clk);
      end
      stall0 = 0;
      run0(1000, 0, 1, n, ns);
      check("lat_rnd", n, 80 + ns);
      check("err_rnd", ec0, exp_err(or0 ? 2 : 0));
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end
endmodule
